// File: rtl/adxl362_rst_pkg.sv
// rtl/adxl362_rst_pkg.sv - shared state and reset-cause definitions for the reset sequencer
package adxl362_rst_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } rst_state_e;

  localparam logic [1:0] CAUSE_MASTER = 2'b00;
  localparam logic [1:0] CAUSE_SOFT   = 2'b01;
  localparam logic [1:0] CAUSE_WDOG   = 2'b10;

endpackage

// File: rtl/adxl362_tick_div.sv
// rtl/adxl362_tick_div.sv - programmable sample-rate strobe, active only while the system runs
module adxl362_tick_div #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] per_q, per_d;
  logic             wrap;

  // A zero period re-samples div every cycle so a later non-zero value can start ticking.
  always_comb begin
    wrap  = (per_q != '0) && (cnt_q == per_q - DIV_W'(1));
    cnt_d = cnt_q;
    per_d = per_q;
    if (load) begin
      cnt_d = '0;
      per_d = div;
    end else if (!run) begin
      cnt_d = '0;
    end else if ((per_q == '0) || wrap) begin
      cnt_d = '0;
      per_d = div;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      per_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      per_q <= per_d;
    end
  end

  assign tick = run && wrap;

endmodule

// File: rtl/adxl362_reset_sequencer.sv
// rtl/adxl362_reset_sequencer.sv - stretched, staggered multi-channel reset release with tick generator
// Optional watchdog reset source enabled by ADXL362_RST_WDOG_EN.
module adxl362_reset_sequencer
  import adxl362_rst_pkg::*;
#(
  parameter int NUM_RST  = 3,
  parameter int STRETCH  = 32,
  parameter int STAGGER  = 8,
  parameter int DIV_W    = 16,
  parameter int WDOG_CYC = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               soft_reset,
  input  logic [DIV_W-1:0]   div,
  input  logic               wdog_kick,
  output logic [NUM_RST-1:0] rst_out,
  output logic               done,
  output logic               tick,
  output logic [1:0]         cause
);

  localparam int CNT_W = $clog2(STRETCH + 1);
  localparam int STG_W = $clog2(STAGGER + 1);
  localparam logic [NUM_RST-1:0] RST_ALL = {NUM_RST{1'b1}};

  rst_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STG_W-1:0]   stg_q, stg_d;
  logic [NUM_RST-1:0] rst_q, rst_d;
  logic [1:0]         cause_q, cause_d;
  logic               wdog_fire;
  logic               src_any;
  logic               run_enter;

`ifdef ADXL362_RST_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYC + 1);
  logic [WD_W-1:0] wd_q, wd_d;

  assign wdog_fire = (state_q == RUN) && !wdog_kick && (wd_q == WD_W'(WDOG_CYC - 1));

  always_comb begin
    wd_d = '0;
    if ((state_q == RUN) && !wdog_kick && !wdog_fire) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic unused_wdog;
  assign unused_wdog = wdog_kick ^ (WDOG_CYC != 0);
  assign wdog_fire   = 1'b0;
`endif

  assign src_any = reset || soft_reset || wdog_fire;

  // Channels release by shifting zeros in from bit 0; an all-zero vector means the last one just fell.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stg_d   = stg_q;
    rst_d   = rst_q;
    cause_d = cause_q;
    if (src_any) begin
      state_d = ASSERT;
      cnt_d   = '0;
      stg_d   = '0;
      rst_d   = RST_ALL;
      cause_d = reset ? CAUSE_MASTER : (soft_reset ? CAUSE_SOFT : CAUSE_WDOG);
    end else begin
      case (state_q)
        ASSERT: begin
          if (cnt_q == CNT_W'(STRETCH - 1)) begin
            cnt_d   = '0;
            rst_d   = rst_q << 1;
            state_d = (rst_d == '0) ? RUN : RELEASE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (stg_q == STG_W'(STAGGER - 1)) begin
            stg_d   = '0;
            rst_d   = rst_q << 1;
            state_d = (rst_d == '0) ? RUN : RELEASE;
          end else begin
            stg_d = stg_q + STG_W'(1);
          end
        end
        RUN:     state_d = RUN;
        default: state_d = ASSERT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ASSERT;
      cnt_q   <= '0;
      stg_q   <= '0;
      rst_q   <= RST_ALL;
      cause_q <= CAUSE_MASTER;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stg_q   <= stg_d;
      rst_q   <= rst_d;
      cause_q <= cause_d;
    end
  end

  assign run_enter = (state_d == RUN) && (state_q != RUN);

  adxl362_tick_div #(
    .DIV_W(DIV_W)
  ) u_tick_div (
    .clk  (clk),
    .reset(reset),
    .run  (state_q == RUN),
    .load (run_enter),
    .div  (div),
    .tick (tick)
  );

  assign rst_out = rst_q;
  assign done    = (state_q == RUN);
  assign cause   = cause_q;

endmodule

// File: tb/tb_adxl362_reset_sequencer.sv
// tb/tb_adxl362_reset_sequencer.sv - directed self-checking bench for adxl362_reset_sequencer
module tb_adxl362_reset_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        soft_reset;
  logic [15:0] div;
  logic        wdog_kick;
  logic [2:0]  rst_out;
  logic        done;
  logic        tick;
  logic [1:0]  cause;

  int n_chk  = 0;
  int n_fail = 0;

  adxl362_reset_sequencer #(
    .NUM_RST (3),
    .STRETCH (32),
    .STAGGER (8),
    .DIV_W   (16),
    .WDOG_CYC(64)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .soft_reset(soft_reset),
    .div       (div),
    .wdog_kick (wdog_kick),
    .rst_out   (rst_out),
    .done      (done),
    .tick      (tick),
    .cause     (cause)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] seq_rst(int n);
    if (n < 32) return 3'b111;
    if (n < 40) return 3'b110;
    if (n < 48) return 3'b100;
    return 3'b000;
  endfunction

  task automatic test_reset();
    logic [2:0] exp;
    reset = 1'b1;
    repeat (5) step();
    n_chk++; if (rst_out !== 3'b111) begin n_fail++; $display("FAIL reset_rst_out: got %b expected 111", rst_out); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_chk++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", tick); end
    n_chk++; if (cause !== 2'b00) begin n_fail++; $display("FAIL reset_cause: got %b expected 00", cause); end
    reset = 1'b0;
    for (int n = 0; n < 56; n++) begin
      exp = seq_rst(n);
      n_chk++; if (rst_out !== exp) begin n_fail++; $display("FAIL master_seq_rst cyc %0d: got %b expected %b", n, rst_out, exp); end
      n_chk++; if (done !== (n >= 48)) begin n_fail++; $display("FAIL master_seq_done cyc %0d: got %b expected %b", n, done, (n >= 48)); end
      step();
    end
    n_chk++; if (cause !== 2'b00) begin n_fail++; $display("FAIL master_cause: got %b expected 00", cause); end
  endtask

  task automatic test_soft_reset();
    logic [2:0] exp;
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    n_chk++; if (cause !== 2'b01) begin n_fail++; $display("FAIL soft_cause: got %b expected 01", cause); end
    for (int n = 0; n < 52; n++) begin
      exp = seq_rst(n);
      n_chk++; if (rst_out !== exp) begin n_fail++; $display("FAIL soft_seq_rst cyc %0d: got %b expected %b", n, rst_out, exp); end
      n_chk++; if (done !== (n >= 48)) begin n_fail++; $display("FAIL soft_seq_done cyc %0d: got %b expected %b", n, done, (n >= 48)); end
      step();
    end
  endtask

  task automatic test_priority();
    reset = 1'b1;
    soft_reset = 1'b1;
    step();
    reset = 1'b0;
    soft_reset = 1'b0;
    n_chk++; if (cause !== 2'b00) begin n_fail++; $display("FAIL prio_cause: got %b expected 00", cause); end
    n_chk++; if (rst_out !== 3'b111) begin n_fail++; $display("FAIL prio_rst_out: got %b expected 111", rst_out); end
    repeat (48) step();
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL prio_done: got %b expected 1", done); end
  endtask

  task automatic test_mid_release();
    logic [2:0] exp;
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    repeat (36) step();
    n_chk++; if (rst_out !== 3'b110) begin n_fail++; $display("FAIL mid_pre_rst: got %b expected 110", rst_out); end
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    n_chk++; if (rst_out !== 3'b111) begin n_fail++; $display("FAIL mid_reassert: got %b expected 111", rst_out); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_done: got %b expected 0", done); end
    n_chk++; if (cause !== 2'b01) begin n_fail++; $display("FAIL mid_cause: got %b expected 01", cause); end
    for (int n = 0; n < 50; n++) begin
      exp = seq_rst(n);
      n_chk++; if (rst_out !== exp) begin n_fail++; $display("FAIL mid_seq_rst cyc %0d: got %b expected %b", n, rst_out, exp); end
      step();
    end
  endtask

  task automatic test_tick_div4();
    logic exp;
    div = 16'd4;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int n = 0; n < 48; n++) begin
      n_chk++; if (tick !== 1'b0) begin n_fail++; $display("FAIL tick_outside_run cyc %0d: got %b expected 0", n, tick); end
      step();
    end
    for (int k = 0; k < 13; k++) begin
      if (k == 5) div = 16'd2;
      exp = (k == 3) || (k == 7) || (k == 9) || (k == 11);
      n_chk++; if (tick !== exp) begin n_fail++; $display("FAIL tick_div4_2 run %0d: got %b expected %b", k, tick, exp); end
      step();
    end
  endtask

  task automatic test_tick_div1();
    div = 16'd1;
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    repeat (47) step();
    n_chk++; if (tick !== 1'b0) begin n_fail++; $display("FAIL tick_div1_pre: got %b expected 0", tick); end
    step();
    for (int k = 0; k < 5; k++) begin
      n_chk++; if (tick !== 1'b1) begin n_fail++; $display("FAIL tick_div1 run %0d: got %b expected 1", k, tick); end
      step();
    end
  endtask

  task automatic test_tick_div0();
    div = 16'd0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (48) step();
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL div0_done: got %b expected 1", done); end
    for (int k = 0; k < 20; k++) begin
      n_chk++; if (tick !== 1'b0) begin n_fail++; $display("FAIL tick_div0 run %0d: got %b expected 0", k, tick); end
      step();
    end
  endtask

  task automatic test_watchdog();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (48) step();
`ifdef ADXL362_RST_WDOG_EN
    for (int k = 0; k < 64; k++) begin
      n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL wdog_run_done run %0d: got %b expected 1", k, done); end
      step();
    end
    n_chk++; if (rst_out !== 3'b111) begin n_fail++; $display("FAIL wdog_fire_rst: got %b expected 111", rst_out); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL wdog_fire_done: got %b expected 0", done); end
    n_chk++; if (cause !== 2'b10) begin n_fail++; $display("FAIL wdog_cause: got %b expected 10", cause); end
    repeat (48) step();
    for (int k = 0; k < 200; k++) begin
      wdog_kick = ((k % 50) == 49);
      n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL wdog_kicked_done run %0d: got %b expected 1", k, done); end
      step();
    end
    wdog_kick = 1'b0;
    n_chk++; if (cause !== 2'b10) begin n_fail++; $display("FAIL wdog_kicked_cause: got %b expected 10", cause); end
`else
    for (int k = 0; k < 150; k++) begin
      wdog_kick = ((k % 50) == 49);
      n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL nowdog_done run %0d: got %b expected 1", k, done); end
      step();
    end
    wdog_kick = 1'b0;
    n_chk++; if (cause !== 2'b00) begin n_fail++; $display("FAIL nowdog_cause: got %b expected 00", cause); end
`endif
  endtask

  initial begin
    reset      = 1'b1;
    soft_reset = 1'b0;
    div        = 16'd0;
    wdog_kick  = 1'b0;
    test_reset();
    test_soft_reset();
    test_priority();
    test_mid_release();
    test_tick_div4();
    test_tick_div1();
    test_tick_div0();
    test_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
